// File: rtl/keypad_entry.sv
// keypad_entry: debounces scanner key codes and runs the two-digit minute entry
// state machine that commits a value to the countdown clock.
module keypad_entry #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int MAX_MINUTE      = 99
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [3:0] key,
   output logic       editing,
   output logic [7:0] digits_bcd,
   output logic       load,
   output logic [6:0] load_minute,
   output logic       error
);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ENTRY  = 1'b1;
   localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;
   localparam logic [3:0] KEY_STAR  = 4'd10;
   localparam logic [3:0] KEY_HASH  = 4'd11;
   localparam logic [3:0] KEY_NONE  = 4'd15;
   localparam logic [7:0] STAB_MAX  = 8'(DEBOUNCE_CYCLES);
   localparam logic [7:0] STAB_LAST = 8'(DEBOUNCE_CYCLES - 1);
   localparam logic [6:0] MAX_LIM   = 7'(MAX_MINUTE);

   logic [3:0] key_prev;
   logic [7:0] stab;
   logic       armed;
   logic       ev_valid;
   logic [3:0] ev_code;
   logic [0:0] state;
   logic [1:0] count;

   logic       same_key;
   logic       stab_reach;
   logic       accept;
   logic [6:0] entry_value;

   always_comb begin
      same_key    = (key == key_prev);
      stab_reach  = same_key && (stab == STAB_LAST);
      // only real keys are accepted; codes 12-14 leave armed untouched
      accept      = stab_reach && armed && (key_prev <= KEY_HASH);
      entry_value = ({3'b000, digits_bcd[7:4]} * 7'd10) + {3'b000, digits_bcd[3:0]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         key_prev <= KEY_NONE;
         stab     <= 8'd0;
         armed    <= 1'b0;
         ev_valid <= 1'b0;
         ev_code  <= 4'd0;
      end else if (en) begin
         key_prev <= key;
         if (!same_key) begin
            stab <= 8'd0;
         end else if (stab != STAB_MAX) begin
            stab <= stab + 8'd1;
         end
         // re-arm only after a stable release, so held keys yield one event
         if (stab_reach && (key_prev == KEY_NONE)) begin
            armed <= 1'b1;
         end else if (accept) begin
            armed <= 1'b0;
         end
         ev_valid <= accept;
         ev_code  <= key_prev;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         count       <= 2'd0;
         editing     <= 1'b0;
         digits_bcd  <= 8'h00;
         load        <= 1'b0;
         load_minute <= 7'd0;
         error       <= 1'b0;
      end else begin
         load  <= 1'b0;
         error <= 1'b0;
         if (en && ev_valid) begin
            case (state)
               ST_IDLE: begin
                  if (ev_code <= KEY_DIGIT_MAX) begin
                     digits_bcd <= {4'h0, ev_code};
                     count      <= 2'd1;
                     state      <= ST_ENTRY;
                     editing    <= 1'b1;
                  end else if (ev_code == KEY_STAR) begin
                     digits_bcd <= 8'h00;
                  end
               end
               ST_ENTRY: begin
                  if (ev_code <= KEY_DIGIT_MAX) begin
                     // rolling entry: a third digit pushes out the old tens
                     digits_bcd <= {digits_bcd[3:0], ev_code};
                     count      <= (count == 2'd2) ? 2'd2 : count + 2'd1;
                  end else if (ev_code == KEY_STAR) begin
                     digits_bcd <= 8'h00;
                     count      <= 2'd0;
                     state      <= ST_IDLE;
                     editing    <= 1'b0;
                  end else if (ev_code == KEY_HASH) begin
                     if (entry_value <= MAX_LIM) begin
                        load_minute <= entry_value;
                        load        <= 1'b1;
                     end else begin
                        error <= 1'b1;
                     end
                     count   <= 2'd0;
                     state   <= ST_IDLE;
                     editing <= 1'b0;
                  end
               end
               default: begin
                  state   <= ST_IDLE;
                  editing <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_keypad_entry.sv
// Self-checking bench for keypad_entry: two instances (MAX_MINUTE 99 and 59) share
// stimulus and are compared each cycle against a history-based behavioural model.
module tb_keypad_entry;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [3:0] key;

   logic       editing_a, load_a, error_a;
   logic [7:0] digits_a;
   logic [6:0] lm_a;
   logic       editing_b, load_b, error_b;
   logic [7:0] digits_b;
   logic [6:0] lm_b;

   always #5 clk = ~clk;

   keypad_entry #(.DEBOUNCE_CYCLES(D), .MAX_MINUTE(99)) dut_a (
      .clk(clk), .rst(rst), .en(en), .key(key),
      .editing(editing_a), .digits_bcd(digits_a), .load(load_a),
      .load_minute(lm_a), .error(error_a)
   );

   keypad_entry #(.DEBOUNCE_CYCLES(D), .MAX_MINUTE(59)) dut_b (
      .clk(clk), .rst(rst), .en(en), .key(key),
      .editing(editing_b), .digits_bcd(digits_b), .load(load_b),
      .load_minute(lm_b), .error(error_b)
   );

   int n_assert = 0;
   int n_fail   = 0;
   int cnt_load_a = 0, cnt_err_a = 0, cnt_load_b = 0, cnt_err_b = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Behavioural model: events come from runs of identical enabled samples.
   int  hist[$];
   bit  m_valid = 1'b0;
   bit  m_armed, m_pend, m_entry;
   int  m_pcode, m_tens, m_ones;
   int  m_lm[2];
   bit  m_ld[2], m_er[2];
   int  maxv[2] = '{99, 59};

   function automatic bit run_complete();
      int n = hist.size();
      if (n < D + 1) return 1'b0;
      for (int j = 1; j <= D; j++)
         if (hist[n-1-j] != hist[n-1]) return 1'b0;
      if (n > D + 1 && hist[n-D-2] == hist[n-1]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic apply(input int code);
      if (code <= 9) begin
         if (m_entry) m_tens = m_ones;
         else m_tens = 0;
         m_ones  = code;
         m_entry = 1'b1;
      end else if (code == 10) begin
         m_tens = 0; m_ones = 0; m_entry = 1'b0;
      end else if (m_entry) begin
         for (int i = 0; i < 2; i++) begin
            if (m_tens * 10 + m_ones <= maxv[i]) begin
               m_lm[i] = m_tens * 10 + m_ones;
               m_ld[i] = 1'b1;
            end else begin
               m_er[i] = 1'b1;
            end
         end
         m_entry = 1'b0;
      end
   endtask

   initial forever begin
      @(posedge clk);
      if (rst) begin
         hist = {15};
         m_armed = 0; m_pend = 0; m_entry = 0; m_tens = 0; m_ones = 0;
         m_lm = '{0, 0}; m_ld = '{0, 0}; m_er = '{0, 0};
         m_valid = 1'b1;
      end else begin
         m_ld = '{0, 0}; m_er = '{0, 0};
         if (en) begin
            if (m_pend) begin
               apply(m_pcode);
               m_pend = 1'b0;
            end
            hist.push_back(int'(key));
            while (hist.size() > D + 2) void'(hist.pop_front());
            if (run_complete()) begin
               if (hist[$] == 15) m_armed = 1'b1;
               else if (hist[$] <= 11 && m_armed) begin
                  m_pend = 1'b1; m_pcode = hist[$]; m_armed = 1'b0;
               end
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (m_valid) begin
         check("editing_a", editing_a, m_entry);
         check("digits_a", digits_a, m_tens * 16 + m_ones);
         check("load_a", load_a, m_ld[0]);
         check("error_a", error_a, m_er[0]);
         check("load_minute_a", lm_a, m_lm[0]);
         check("editing_b", editing_b, m_entry);
         check("digits_b", digits_b, m_tens * 16 + m_ones);
         check("load_b", load_b, m_ld[1]);
         check("error_b", error_b, m_er[1]);
         check("load_minute_b", lm_b, m_lm[1]);
         check("pulse_excl_a", load_a & error_a, 1'b0);
         if (load_a === 1'b1) cnt_load_a++;
         if (error_a === 1'b1) cnt_err_a++;
         if (load_b === 1'b1) cnt_load_b++;
         if (error_b === 1'b1) cnt_err_b++;
      end
   end

   task automatic drive(input logic [3:0] k, input logic e, input logic r, input int n);
      for (int i = 0; i < n; i++) begin
         key = k; en = e; rst = r;
         @(posedge clk);
         #2;
      end
   endtask

   task automatic press(input logic [3:0] k);
      drive(k, 1'b1, 1'b0, 8);
      drive(4'd15, 1'b1, 1'b0, 6);
   endtask

   int la0, ea0, lb0, eb0;

   initial begin
      key = 4'd15; en = 1'b1; rst = 1'b1;
      drive(4'd15, 1'b1, 1'b1, 2);
      check("reset_digits", digits_a, 8'h00);
      check("reset_editing", editing_a, 1'b0);

      // basic entry 2,5,#
      drive(4'd15, 1'b1, 1'b0, 6);
      la0 = cnt_load_a;
      drive(4'd2, 1'b1, 1'b0, 8);
      check("t1_first_digit", digits_a, 8'h02);
      check("t1_editing", editing_a, 1'b1);
      drive(4'd15, 1'b1, 1'b0, 6);
      drive(4'd5, 1'b1, 1'b0, 8);
      check("t1_second_digit", digits_a, 8'h25);
      drive(4'd15, 1'b1, 1'b0, 6);
      press(4'd11);
      check("t1_load_minute", lm_a, 7'd25);
      check("t1_load_count", cnt_load_a - la0, 1);
      check("t1_editing_after", editing_a, 1'b0);

      // glitches rejected, held key gives one event at edge N+5
      drive(4'd15, 1'b1, 1'b1, 2);
      drive(4'd15, 1'b1, 1'b0, 6);
      repeat (2) begin
         drive(4'd7, 1'b1, 1'b0, 3);
         drive(4'd15, 1'b1, 1'b0, 6);
      end
      check("t2_glitch", digits_a, 8'h00);
      drive(4'd7, 1'b1, 1'b0, 5);
      check("t2_before_edge5", digits_a, 8'h00);
      drive(4'd7, 1'b1, 1'b0, 1);
      check("t2_at_edge5", digits_a, 8'h07);
      drive(4'd7, 1'b1, 1'b0, 14);
      check("t2_single_event", digits_a, 8'h07);
      drive(4'd15, 1'b1, 1'b0, 6);
      press(4'd10);

      // rolling entry 1,2,3,#
      la0 = cnt_load_a;
      press(4'd1); press(4'd2);
      check("t3_12", digits_a, 8'h12);
      press(4'd3);
      check("t3_23", digits_a, 8'h23);
      press(4'd11);
      check("t3_load_minute", lm_a, 7'd23);
      check("t3_load_count", cnt_load_a - la0, 1);

      // clear and lone '#'
      la0 = cnt_load_a; ea0 = cnt_err_a;
      press(4'd4);
      check("t4_digit", digits_a, 8'h04);
      press(4'd10);
      check("t4_clear", digits_a, 8'h00);
      check("t4_clear_edit", editing_a, 1'b0);
      press(4'd11);
      check("t4_no_load", cnt_load_a - la0, 0);
      check("t4_no_error", cnt_err_a - ea0, 0);

      // invalid code 13 must not disarm
      drive(4'd13, 1'b1, 1'b0, 8);
      drive(4'd3, 1'b1, 1'b0, 8);
      check("t4_after_13", digits_a, 8'h03);
      drive(4'd15, 1'b1, 1'b0, 6);
      press(4'd10);

      // 75 rejected by the MAX_MINUTE=59 instance
      drive(4'd15, 1'b1, 1'b1, 2);
      drive(4'd15, 1'b1, 1'b0, 6);
      lb0 = cnt_load_b; eb0 = cnt_err_b;
      press(4'd7); press(4'd5); press(4'd11);
      check("t5_err_b", cnt_err_b - eb0, 1);
      check("t5_load_b", cnt_load_b - lb0, 0);
      check("t5_lm_b", lm_b, 7'd0);
      check("t5_lm_a", lm_a, 7'd75);

      // reset mid-entry, key held through reset, en low during hold
      drive(4'd8, 1'b1, 1'b0, 8);
      check("t6_entry", digits_a, 8'h08);
      drive(4'd15, 1'b1, 1'b1, 1);
      check("t6_rst_digits", digits_a, 8'h00);
      check("t6_rst_edit", editing_a, 1'b0);
      check("t6_rst_lm", lm_a, 7'd0);
      drive(4'd9, 1'b1, 1'b1, 3);
      drive(4'd9, 1'b1, 1'b0, 10);
      check("t6_held_thru_rst", digits_a, 8'h00);
      drive(4'd15, 1'b1, 1'b0, 6);
      drive(4'd6, 1'b1, 1'b0, 2);
      drive(4'd6, 1'b0, 1'b0, 10);
      drive(4'd6, 1'b1, 1'b0, 2);
      check("t6_en_hold", digits_a, 8'h00);
      drive(4'd6, 1'b1, 1'b0, 2);
      check("t6_en_resume", digits_a, 8'h06);
      drive(4'd15, 1'b1, 1'b0, 6);
      la0 = cnt_load_a;
      drive(4'd11, 1'b1, 1'b0, 6);
      check("t6_load_pulse", load_a, 1'b1);
      drive(4'd11, 1'b0, 1'b0, 4);
      check("t6_load_clears", load_a, 1'b0);
      check("t6_load_count", cnt_load_a - la0, 1);
      check("t6_lm", lm_a, 7'd6);
      drive(4'd15, 1'b1, 1'b0, 6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
